// File: rtl/irq_rr_arbiter32_pkg.sv
// rtl/irq_rr_arbiter32_pkg.sv - shared constants and state encoding for the 32-source round-robin interrupt arbiter
package irq_rr_arbiter32_pkg;

    localparam int N_SRC = 32;
    localparam int IDX_W = 5;

    localparam bit EDGE_TRIG_DEFAULT = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/irq_rr_pick32.sv
// rtl/irq_rr_pick32.sv - combinational rotating-priority picker over 32 eligible sources
module rr_pick32
    import irq_rr_arbiter32_pkg::*;
(
    input  logic [N_SRC-1:0] elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_SRC-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_SRC-1:0] rot;
    logic [IDX_W-1:0] rot_idx;
    logic             found;

    // Rotate so that ptr lands on bit 0, take the lowest set bit, then rotate the index back.
    // The 5-bit add wraps naturally mod 32, and a shift by 32 on a 32-bit value yields 0 when ptr is 0.
    always_comb begin
        rot     = (elig >> ptr) | (elig << (6'd32 - {1'b0, ptr}));
        rot_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && rot[i]) begin
                rot_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
        any    = |elig;
        idx    = rot_idx + ptr;
        onehot = any ? (32'd1 << idx) : '0;
    end

endmodule

// File: rtl/irq_rr_arbiter32.sv
// rtl/irq_rr_arbiter32.sv - pending-latch interrupt arbiter with round-robin one-hot grant and ack handshake
module irq_rr_arbiter32
    import irq_rr_arbiter32_pkg::*;
#(
    parameter bit EDGE_TRIG = EDGE_TRIG_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      irq_in,
    input  logic [31:0]      irq_mask,
    input  logic             grant_ack,
    output logic             grant_valid,
    output logic [31:0]      grant_onehot,
    output logic [31:0]      pending,
    output logic [IDX_W-1:0] rr_ptr
);

    arb_state_e       state_q, state_d;
    logic [31:0]      pending_q, pending_d;
    logic [31:0]      irq_prev_q;
    logic [31:0]      grant_q, grant_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [31:0]      set_vec;
    logic [31:0]      clr_vec;
    logic [31:0]      elig;
    logic             ack_acc;
    logic [31:0]      pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    assign elig    = pending_q & irq_mask;
    assign ack_acc = (state_q == ST_GRANT) && grant_ack;

    rr_pick32 u_pick (
        .elig   (elig),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Pending update: in edge mode a new rising edge wins over a same-cycle ack clear of that bit.
    always_comb begin
        set_vec = irq_in & ~irq_prev_q;
        clr_vec = ack_acc ? grant_q : '0;
        if (EDGE_TRIG) begin
            pending_d = (pending_q & ~clr_vec) | set_vec;
        end else begin
            pending_d = irq_in;
        end
    end

    // Grant FSM: register a pick in IDLE, hold it unchanged in GRANT until acked.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (grant_ack) begin
                    grant_d  = '0;
                    rr_ptr_d = gidx_q + IDX_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset drops any outstanding grant without needing an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            irq_prev_q <= '0;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq_in;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign grant_valid  = (state_q == ST_GRANT);
    assign grant_onehot = grant_q;
    assign pending      = pending_q;
    assign rr_ptr       = rr_ptr_q;

endmodule

// File: doc/irq_rr_arbiter32.md
Name: irq_rr_arbiter32

Overview:
- Collects 32 interrupt/exception request lines and latches them into a pending register.
- Picks exactly one enabled pending source using rotating (round-robin) priority.
- Presents the pick as a stable one-hot vector with a valid/ack handshake.
- Sits directly upstream of the one-hot-to-5-bit encoder stage; its one-hot output drives that encoder's 32-bit input unchanged.

Parameters:
- EDGE_TRIG, 1, 1 = pending bit sets on a rising edge of irq_in and clears on ack; 0 = level mode, pending mirrors registered irq_in.
- N_SRC, 32, number of sources; fixed at 32, not to be overridden.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- irq_in  in  32  raw request lines, synchronous to clk
- irq_mask  in  32  1 = source enabled for arbitration
- grant_ack  in  1  consumer accepts the current grant
- grant_valid  out  1  grant_onehot holds a valid pick
- grant_onehot  out  32  exactly one bit set when grant_valid=1; all zero otherwise
- pending  out  32  current pending register, for status readback
- rr_ptr  out  5  index of the highest-priority source for the next pick

Behaviour:
- Reset (rst=1 at a clk edge):
  - pending=0, irq_prev=0, rr_ptr=0, state=IDLE.
  - grant_valid=0, grant_onehot=0.
  - rst overrides every other input, including mid-grant; the grant is dropped with no ack needed.
- Edge mode:
  - set_vec = irq_in & ~irq_prev; irq_prev <= irq_in every cycle.
  - A line held high across reset release counts as an edge on the first post-reset cycle.
- Pending update: pending <= (pending & ~clr_vec) | set_vec.
  - clr_vec = grant_onehot when an ack is accepted, else 0.
  - A set on bit k beats a clear of bit k in the same cycle: the bit stays 1.
- Level mode: pending <= irq_in; ack does not clear it; the source must deassert.
- Masked pending bits stay latched but are not eligible for arbitration.
- Eligible vector: elig = pending & irq_mask.
- Pick: the first set bit of elig, searching rr_ptr, rr_ptr+1, ..., 31, 0, ..., rr_ptr-1 (mod 32).
- State machine (2 states):
  - IDLE: grant_valid=0. If elig != 0, register the pick into grant_onehot and go to GRANT on the next edge.
  - GRANT: grant_valid=1, grant_onehot held stable. Mask and irq_in changes do not alter or withdraw the grant.
    - On grant_ack=1: clear the granted pending bit (edge mode), set rr_ptr <= (g+1) mod 32 where g is the granted index (31 wraps to 0), go to IDLE.
    - In IDLE after an ack: grant_valid=0, grant_onehot=0.
    - Bubble: at least one IDLE cycle always separates consecutive grants.
- grant_ack while in IDLE is ignored.
- Latency (edge mode): irq_in rises and is sampled at edge t; pending bit is 1 after t+1; grant_valid=1 after t+2. Minimum grant-to-grant spacing is 2 cycles with an immediate ack.
- Outputs grant_valid, grant_onehot and rr_ptr are registered. pending is the register itself.
- Invariant for verification: popcount(grant_onehot) is 1 when valid and 0 otherwise.

Decomposition:
- Shared package holds:
  - N_SRC=32, IDX_W=5
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - the EDGE_TRIG default
- One combinational sub-module, rr_pick32:
  - inputs: elig[31:0], ptr[4:0]
  - outputs: onehot[31:0], idx[4:0], any
  - implementation: rotate right by ptr, fixed LSB-first priority, rotate back. idx is used for the rr_ptr update.

Test Plan:
- Reset, then pulse irq_in[5] for 1 cycle with mask all-ones -> grant_valid=1 two cycles later with grant_onehot=32'h0000_0020; ack -> pending[5]=0, rr_ptr=6, grant_valid=0 the next cycle.
- Sources 3 and 10 both pending, rr_ptr=0 -> grant 3, ack; then grant 10 (rr_ptr=4), ack -> rr_ptr=11, pending=0.
- Wrap: rr_ptr=30, sources 31 and 1 pending -> grant 31, ack -> rr_ptr=0, then grant 1.
- Mask: source 7 pending, mask[7]=0 -> no grant for 20 cycles. Set mask[7]=1 -> grant 0x80 the next cycle. Clearing mask mid-grant keeps 0x80 until ack.
- Simultaneous ack clear and new edge on bit 4 -> pending[4] stays 1 and bit 4 is re-granted after the bubble. ack asserted in IDLE -> no state change.
- rst asserted during GRANT with 3 bits pending -> the next cycle shows all outputs 0 and rr_ptr=0; nothing is re-granted without new edges.
